// File: rtl/segre_mm_ctrl.sv
// segre_mm_ctrl: fixed-latency lane memory controller with a single outstanding read or write.
// Define SEGRE_MM_STATS_EN to add saturating read/write completion counters.
module segre_mm_ctrl #(
    parameter int ADDR_SIZE  = 32,
    parameter int LANE_SIZE  = 128,
    parameter int MEM_LANES  = 4096,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 2
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 mm_rd_i,
    input  logic                 mm_wr_i,
    input  logic [ADDR_SIZE-1:0] mm_addr_i,
    input  logic [ADDR_SIZE-1:0] mm_wr_addr_i,
    input  logic [LANE_SIZE-1:0] mm_wr_data_i,
    output logic                 mm_data_rdy_o,
    output logic [LANE_SIZE-1:0] mm_rd_data_o,
    output logic                 mm_busy_o
`ifdef SEGRE_MM_STATS_EN
    ,
    output logic [31:0]          rd_count_o,
    output logic [31:0]          wr_count_o
`endif
);
    localparam int OFF   = $clog2(LANE_SIZE / 8);
    localparam int IDX_W = $clog2(MEM_LANES);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

    state_t                 r_state, w_next;
    logic [3:0]             r_cnt;
    logic [ADDR_SIZE-1:0]   r_addr;
    logic [LANE_SIZE-1:0]   r_data;
    logic [LANE_SIZE-1:0]   r_rd_data;
    logic [LANE_SIZE-1:0]   r_mem [MEM_LANES];
    logic [IDX_W-1:0]       w_lane;
    logic                   w_rd_done, w_wr_done;

    assign w_lane        = IDX_W'((r_addr >> OFF) % ADDR_SIZE'(MEM_LANES));
    assign w_rd_done     = (r_state == RD_WAIT) && (r_cnt == 4'd0);
    assign w_wr_done     = (r_state == WR_WAIT) && (r_cnt == 4'd0);
    assign mm_data_rdy_o = (r_state == RESP);
    assign mm_busy_o     = (r_state != IDLE);
    assign mm_rd_data_o  = r_rd_data;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:             w_next = mm_wr_i ? WR_WAIT : (mm_rd_i ? RD_WAIT : IDLE);
            RD_WAIT, WR_WAIT: w_next = (r_cnt == 4'd0) ? RESP : r_state;
            default:          w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_rd_data <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && mm_wr_i) begin
                r_addr <= mm_wr_addr_i;
                r_data <= mm_wr_data_i;
                r_cnt  <= 4'(WR_LATENCY - 1);
            end else if (r_state == IDLE && mm_rd_i) begin
                r_addr <= mm_addr_i;
                r_cnt  <= 4'(RD_LATENCY - 1);
            end else if ((r_state == RD_WAIT || r_state == WR_WAIT) && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_rd_done)
                r_rd_data <= r_mem[w_lane];
        end
    end

    // Backing array survives reset; an async reset leaves WR_WAIT before the commit edge.
    always_ff @(posedge clk_i) begin
        if (w_wr_done)
            r_mem[w_lane] <= r_data;
    end

`ifdef SEGRE_MM_STATS_EN
    logic [31:0] r_rd_cnt, r_wr_cnt;

    assign rd_count_o = r_rd_cnt;
    assign wr_count_o = r_wr_cnt;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_done && r_rd_cnt != 32'hFFFF_FFFF)
                r_rd_cnt <= r_rd_cnt + 32'd1;
            if (w_wr_done && r_wr_cnt != 32'hFFFF_FFFF)
                r_wr_cnt <= r_wr_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_segre_mm_ctrl.sv
// tb_segre_mm_ctrl: directed scoreboard bench for segre_mm_ctrl at default parameters.
module tb_segre_mm_ctrl;
    logic         clk_i = 1'b0;
    logic         rsn_i = 1'b0;
    logic         mm_rd_i = 1'b0;
    logic         mm_wr_i = 1'b0;
    logic [31:0]  mm_addr_i = '0;
    logic [31:0]  mm_wr_addr_i = '0;
    logic [127:0] mm_wr_data_i = '0;
    logic         mm_data_rdy_o;
    logic [127:0] mm_rd_data_o;
    logic         mm_busy_o;
`ifdef SEGRE_MM_STATS_EN
    logic [31:0]  rd_count_o, wr_count_o;
`endif

    segre_mm_ctrl dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .mm_rd_i(mm_rd_i), .mm_wr_i(mm_wr_i),
        .mm_addr_i(mm_addr_i), .mm_wr_addr_i(mm_wr_addr_i), .mm_wr_data_i(mm_wr_data_i),
        .mm_data_rdy_o(mm_data_rdy_o), .mm_rd_data_o(mm_rd_data_o), .mm_busy_o(mm_busy_o)
`ifdef SEGRE_MM_STATS_EN
        , .rd_count_o(rd_count_o), .wr_count_o(wr_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit           rd;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_rd = 0;
    int   n_wr = 0;
    bit   counting = 0;
    int   low_cnt = 0;
    int   a;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) if (counting && !mm_busy_o) low_cnt <= low_cnt + 1;

    // Monitor: every completion pulse must match the oldest expected response.
    always @(negedge clk_i) begin
        if (rsn_i && mm_data_rdy_o) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rdy at cycle %0d: no response was expected", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc || (e.rd && mm_rd_data_o !== e.data)) begin
                    n_err++;
                    $display("FAIL %s_resp: got cycle %0d data %h, need cycle %0d data %h",
                             e.rd ? "rd" : "wr", cyc, mm_rd_data_o, e.cyc, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, need %h", name, act, req);
        end
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [31:0] ra,
                         input logic [31:0] wa, input logic [127:0] wd);
        @(negedge clk_i);
        mm_rd_i = rd; mm_wr_i = wr; mm_addr_i = ra; mm_wr_addr_i = wa; mm_wr_data_i = wd;
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input bit rd, input logic [127:0] d, input int c);
        exp_t e;
        e.rd = rd; e.data = d; e.cyc = c;
        q.push_back(e);
        if (rd) n_rd++; else n_wr++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (mm_busy_o && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        n_vec++;
        if (mm_busy_o) begin
            n_err++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles, need 0", mm_busy_o, n);
        end
    endtask

    task automatic op(input bit rd, input logic [31:0] addr, input logic [127:0] d);
        drive(rd, !rd, addr, addr, d);
        push(rd, d, cyc + (rd ? 4 : 2));
        mm_rd_i = 0; mm_wr_i = 0;
        wait_idle();
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check("reset_rdy", 128'(mm_data_rdy_o), 128'd0);
        check("reset_busy", 128'(mm_busy_o), 128'd0);
        check("reset_rd_data", mm_rd_data_o, 128'd0);
        rsn_i = 1'b1;

        op(0, 32'h40, 128'hDEADBEEF0);
        op(1, 32'h40, 128'hDEADBEEF0);

        // Simultaneous requests: write wins, held read is accepted one idle cycle after RESP.
        drive(1, 1, 32'h80, 32'h80, 128'h1234);
        a = cyc;
        push(0, 128'h1234, a + 2);
        push(1, 128'h1234, a + 8);
        mm_wr_i = 0;
        repeat (4) @(posedge clk_i);
        #1 mm_rd_i = 0;
        wait_idle();

        op(0, 32'h0, 128'hAA);
        op(1, 32'h10000, 128'hAA);

        // Reset in the second WR_WAIT cycle must discard the write to lane 5.
        op(0, 32'h50, 128'h5555);
        op(1, 32'h80, 128'h1234);
        drive(0, 1, 32'h0, 32'h50, 128'h9999);
        mm_wr_i = 0;
        @(posedge clk_i);
        #1 rsn_i = 1'b0;
        #1;
        check("async_rst_busy", 128'(mm_busy_o), 128'd0);
        check("async_rst_rdy", 128'(mm_data_rdy_o), 128'd0);
        check("async_rst_rd_data", mm_rd_data_o, 128'd0);
        repeat (3) @(negedge clk_i);
        rsn_i = 1'b1;
        op(1, 32'h50, 128'h5555);

        // Held read: one pulse per acceptance, busy low for exactly one cycle between.
        drive(1, 0, 32'h40, 32'h0, 128'h0);
        a = cyc;
        counting = 1;
        push(1, 128'hDEADBEEF0, a + 4);
        push(1, 128'hDEADBEEF0, a + 10);
        repeat (6) @(posedge clk_i);
        #1 mm_rd_i = 0;
        repeat (4) @(posedge clk_i);
        #1 counting = 0;
        check("busy_low_gap", 128'(low_cnt), 128'd1);
        wait_idle();
        repeat (3) @(negedge clk_i);
        check("queue_empty", 128'(q.size()), 128'd0);
`ifdef SEGRE_MM_STATS_EN
        check("rd_count", 128'(rd_count_o), 128'(n_rd));
        check("wr_count", 128'(wr_count_o), 128'(n_wr));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench still running at %0t, need completion", $time);
        $fatal(1, "timeout");
    end
endmodule
